// File: rtl/sys_defs.sv
// sys_defs: shared bus, memory-size and load/store arbiter types
package sys_defs;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} BUS_COMMAND;
   typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} MEM_SIZE;
   typedef enum logic [1:0] {IDLE = 2'h0, ISSUE = 2'h1, WAIT = 2'h2, DRAIN = 2'h3} ls_arb_state_t;
endpackage

// File: rtl/ld_align.sv
// ld_align: picks the byte/halfword of a loaded word and sign/zero-extends it
module ld_align
   import sys_defs::*;
(
   input  logic [XLEN-1:0] data,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   logic        misaligned;
   assign b = data[{offset, 3'b000} +: 8];
   assign h = data[{offset[1], 4'b0000} +: 16];
   // misaligned accesses hand back the raw word untouched
   assign misaligned = (funct3[1:0] == 2'd1 && offset[0]) || (funct3[1:0] == 2'd2 && offset != 2'd0);
   assign result = misaligned            ? data :
                   funct3[1:0] == 2'd0   ? {{(XLEN-8){b[7] & ~funct3[2]}}, b} :
                   funct3[1:0] == 2'd1   ? {{(XLEN-16){h[15] & ~funct3[2]}}, h} :
                   data;
endmodule

// File: rtl/ls_mem_arb.sv
// ls_mem_arb: round-robin arbiter giving two load/store FUs one tagged memory port
module ls_mem_arb
   import sys_defs::*;
#(
   parameter int MEM_TAG_W = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 squash,
   input  logic [1:0]           req_valid,
   input  logic [1:0]           req_rd_mem,
   input  logic [1:0]           req_wr_mem,
   input  logic [1:0][XLEN-1:0] req_addr,
   input  logic [1:0][XLEN-1:0] req_wdata,
   input  logic [1:0][2:0]      req_size,
   input  logic [1:0][4:0]      req_dest,
   output logic [1:0]           req_grant,
   output BUS_COMMAND           mem_command,
   output logic [XLEN-1:0]      mem_addr,
   output logic [XLEN-1:0]      mem_wdata,
   output MEM_SIZE              mem_size,
   input  logic [MEM_TAG_W-1:0] mem_response,
   input  logic [MEM_TAG_W-1:0] mem_tag,
   input  logic [XLEN-1:0]      mem_rdata,
   output logic [1:0]           done_valid,
   output logic [XLEN-1:0]      done_data,
   output logic [4:0]           done_dest
);
   ls_arb_state_t        state;
   logic                 rr_ptr, owner, rd_q, wr_q, win, go, accept, hit;
   logic [XLEN-1:0]      addr_q, wdata_q, ld_data;
   logic [2:0]           size_q;
   logic [4:0]           dest_q;
   logic [MEM_TAG_W-1:0] tag_q;
   BUS_COMMAND           issue_cmd;
   assign win         = &req_valid ? rr_ptr : req_valid[1];
   assign go          = state == IDLE && |req_valid && !squash && !reset;
   assign req_grant   = go ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign issue_cmd   = wr_q ? BUS_STORE : rd_q ? BUS_LOAD : BUS_NONE;
   assign mem_command = (state == ISSUE && !squash) ? issue_cmd : BUS_NONE;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_size    = MEM_SIZE'(size_q[1:0]);
   assign accept      = mem_response != '0;
   // tag_q is cleared on every return to IDLE so a stale tag can never match
   assign hit         = tag_q != '0 && mem_tag == tag_q;
   ld_align u_align (
      .data   (mem_rdata),
      .offset (addr_q[1:0]),
      .funct3 (size_q),
      .result (ld_data)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         owner      <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         dest_q     <= '0;
         tag_q      <= '0;
         done_valid <= '0;
         done_data  <= '0;
         done_dest  <= '0;
      end else begin
         done_valid <= '0;
         done_data  <= '0;
         done_dest  <= '0;
         case (state)
            IDLE: if (go) begin
               owner   <= win;
               rr_ptr  <= ~win;
               rd_q    <= req_rd_mem[win];
               wr_q    <= req_wr_mem[win];
               addr_q  <= req_addr[win];
               wdata_q <= req_wdata[win];
               size_q  <= req_size[win];
               dest_q  <= req_dest[win];
               state   <= ISSUE;
            end
            ISSUE: if (squash) begin
               tag_q <= (accept && !wr_q) ? mem_response : '0;
               state <= (accept && !wr_q) ? DRAIN : IDLE;
            end else if (accept) begin
               tag_q <= wr_q ? '0 : mem_response;
               state <= wr_q ? IDLE : WAIT;
               done_valid <= wr_q ? (owner ? 2'b10 : 2'b01) : 2'b00;
            end
            WAIT: if (hit) begin
               // a squash coinciding with the return drops the result instead of draining forever
               tag_q <= '0;
               state <= IDLE;
               done_valid <= squash ? 2'b00 : (owner ? 2'b10 : 2'b01);
               done_data  <= squash ? '0 : ld_data;
               done_dest  <= squash ? '0 : dest_q;
            end else if (squash) begin
               state <= DRAIN;
            end
            DRAIN: if (hit) begin
               tag_q <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ls_mem_arb.sv
// tb_ls_mem_arb: directed and randomized checks of ls_mem_arb against a transaction-level model
module tb_ls_mem_arb;
   import sys_defs::*;
   logic             clock, reset, squash;
   logic [1:0]       req_valid, req_rd_mem, req_wr_mem, req_grant, done_valid;
   logic [1:0][31:0] req_addr, req_wdata;
   logic [1:0][2:0]  req_size;
   logic [1:0][4:0]  req_dest;
   BUS_COMMAND       mem_command;
   MEM_SIZE          mem_size;
   logic [31:0]      mem_addr, mem_wdata, mem_rdata, done_data;
   logic [3:0]       mem_response, mem_tag;
   logic [4:0]       done_dest;
   int passed = 0;
   int total = 0;
   ls_mem_arb #(.MEM_TAG_W(4)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .req_valid(req_valid), .req_rd_mem(req_rd_mem), .req_wr_mem(req_wr_mem),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_dest(req_dest),
      .req_grant(req_grant), .mem_command(mem_command), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_response(mem_response),
      .mem_tag(mem_tag), .mem_rdata(mem_rdata), .done_valid(done_valid),
      .done_data(done_data), .done_dest(done_dest)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic clear_inputs();
      squash = 0; req_valid = 0; req_rd_mem = 0; req_wr_mem = 0;
      req_addr = '0; req_wdata = '0; req_size = '0; req_dest = '0;
      mem_response = 0; mem_tag = 0; mem_rdata = 0;
   endtask
   task automatic do_reset();
      clear_inputs();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask
   // Expected load result from the byte-lane rules, by arithmetic on the loaded word
   function automatic logic [31:0] ref_ld(input logic [31:0] d, input int off, input logic [2:0] f3);
      logic [31:0] b, h;
      b = (d >> (8 * off)) & 32'hFF;
      h = (d >> (8 * off)) & 32'hFFFF;
      if ((f3 == 3'd1 || f3 == 3'd5) && off % 2 == 1) return d;
      if (f3 == 3'd0) return b >= 128 ? b + 32'hFFFF_FF00 : b;
      if (f3 == 3'd4) return b;
      if (f3 == 3'd1) return h >= 32768 ? h + 32'hFFFF_0000 : h;
      if (f3 == 3'd5) return h;
      return d;
   endfunction
   task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                           output logic [1:0] dv, output logic [31:0] dd);
      req_valid = 2'b01; req_rd_mem = 2'b01; req_wr_mem = 2'b00;
      req_addr[0] = addr; req_size[0] = f3; req_dest[0] = 5'd1;
      step();
      req_valid = 0; mem_response = 4'd2;
      step();
      mem_response = 0; mem_tag = 4'd2; mem_rdata = rdata;
      step();
      mem_tag = 0;
      dv = done_valid;
      dd = done_data;
   endtask
   task automatic test_reset();
      do_reset();
      #1;
      total++; if (mem_command !== BUS_NONE) $display("FAIL reset_cmd act=%0d exp=%0d", mem_command, BUS_NONE); else passed++;
      total++; if (req_grant !== 2'b00) $display("FAIL reset_grant act=%b exp=00", req_grant); else passed++;
      total++; if (done_valid !== 2'b00) $display("FAIL reset_done act=%b exp=00", done_valid); else passed++;
      total++; if (mem_addr !== 32'h0) $display("FAIL reset_addr act=%h exp=0", mem_addr); else passed++;
      total++; if (done_data !== 32'h0) $display("FAIL reset_data act=%h exp=0", done_data); else passed++;
   endtask
   task automatic test_single_load();
      do_reset();
      req_valid = 2'b01; req_rd_mem = 2'b01; req_addr[0] = 32'h100; req_size[0] = 3'd2; req_dest[0] = 5'd9;
      #1;
      total++; if (req_grant !== 2'b01) $display("FAIL sl_grant act=%b exp=01", req_grant); else passed++;
      step();
      req_valid = 0; mem_response = 4'd3;
      #1;
      total++; if (mem_command !== BUS_LOAD) $display("FAIL sl_cmd act=%0d exp=%0d", mem_command, BUS_LOAD); else passed++;
      total++; if (mem_addr !== 32'h100) $display("FAIL sl_addr act=%h exp=100", mem_addr); else passed++;
      step();
      mem_response = 0;
      #1;
      total++; if (mem_command !== BUS_NONE) $display("FAIL sl_wait_cmd act=%0d exp=%0d", mem_command, BUS_NONE); else passed++;
      step();
      step();
      mem_tag = 4'd3; mem_rdata = 32'hDEAD_BEEF;
      #1;
      total++; if (done_valid !== 2'b00) $display("FAIL sl_early_done act=%b exp=00", done_valid); else passed++;
      step();
      mem_tag = 0;
      total++; if (done_valid !== 2'b01) $display("FAIL sl_done act=%b exp=01", done_valid); else passed++;
      total++; if (done_data !== 32'hDEAD_BEEF) $display("FAIL sl_data act=%h exp=deadbeef", done_data); else passed++;
      total++; if (done_dest !== 5'd9) $display("FAIL sl_dest act=%0d exp=9", done_dest); else passed++;
      step();
      total++; if (done_valid !== 2'b00) $display("FAIL sl_pulse act=%b exp=00", done_valid); else passed++;
   endtask
   task automatic test_contention();
      logic [1:0] exp;
      do_reset();
      exp = 2'b01;
      req_valid = 2'b11; req_wr_mem = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (req_grant !== exp) $display("FAIL rr_grant%0d act=%b exp=%b", i, req_grant, exp); else passed++;
         step();
         mem_response = 4'd1;
         #1;
         total++; if (req_grant !== 2'b00) $display("FAIL rr_busy%0d act=%b exp=00", i, req_grant); else passed++;
         step();
         mem_response = 0;
         total++; if (done_valid !== exp) $display("FAIL rr_done%0d act=%b exp=%b", i, done_valid, exp); else passed++;
         exp = (exp == 2'b01) ? 2'b10 : 2'b01;
      end
      clear_inputs();
   endtask
   task automatic test_load_extract();
      logic [31:0] addrs [7];
      logic [2:0]  f3s [7];
      logic [31:0] exps [7];
      logic [1:0]  dv;
      logic [31:0] dd;
      addrs = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h102, 32'h100};
      f3s   = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd2, 3'd0};
      exps  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_FF00, 32'h80FF_FF00, 32'h0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         run_load(addrs[i], f3s[i], 32'h80FF_FF00, dv, dd);
         total++; if (dv !== 2'b01) $display("FAIL ext_valid%0d act=%b exp=01", i, dv); else passed++;
         total++; if (dd !== exps[i]) $display("FAIL ext_data%0d act=%h exp=%h", i, dd, exps[i]); else passed++;
      end
   endtask
   task automatic test_store_backpressure();
      do_reset();
      req_valid = 2'b10; req_wr_mem = 2'b10; req_addr[1] = 32'h20; req_wdata[1] = 32'h1234_5678; req_size[1] = 3'd2;
      #1;
      total++; if (req_grant !== 2'b10) $display("FAIL st_grant act=%b exp=10", req_grant); else passed++;
      step();
      req_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (mem_command !== BUS_STORE) $display("FAIL st_hold%0d act=%0d exp=%0d", i, mem_command, BUS_STORE); else passed++;
         total++; if (done_valid !== 2'b00) $display("FAIL st_nodone%0d act=%b exp=00", i, done_valid); else passed++;
         step();
      end
      mem_response = 4'd5;
      #1;
      total++; if (mem_command !== BUS_STORE) $display("FAIL st_acc_cmd act=%0d exp=%0d", mem_command, BUS_STORE); else passed++;
      total++; if (mem_wdata !== 32'h1234_5678) $display("FAIL st_wdata act=%h exp=12345678", mem_wdata); else passed++;
      total++; if (mem_size !== WORD) $display("FAIL st_size act=%0d exp=%0d", mem_size, WORD); else passed++;
      step();
      mem_response = 0;
      total++; if (done_valid !== 2'b10) $display("FAIL st_done act=%b exp=10", done_valid); else passed++;
      total++; if (done_data !== 32'h0) $display("FAIL st_data act=%h exp=0", done_data); else passed++;
   endtask
   task automatic test_squash();
      do_reset();
      squash = 1; req_valid = 2'b01; req_rd_mem = 2'b01; req_addr[0] = 32'h40; req_size[0] = 3'd2;
      #1;
      total++; if (req_grant !== 2'b00) $display("FAIL sq_idle_grant act=%b exp=00", req_grant); else passed++;
      step();
      squash = 0;
      #1;
      total++; if (req_grant !== 2'b01) $display("FAIL sq_after_grant act=%b exp=01", req_grant); else passed++;
      step();
      req_valid = 0; mem_response = 4'd5;
      step();
      mem_response = 0; squash = 1;
      step();
      squash = 0;
      step();
      mem_tag = 4'd5; mem_rdata = 32'hAAAA_AAAA; req_valid = 2'b01;
      #1;
      total++; if (req_grant !== 2'b00) $display("FAIL sq_drain_grant act=%b exp=00", req_grant); else passed++;
      step();
      mem_tag = 0;
      #1;
      total++; if (done_valid !== 2'b00) $display("FAIL sq_drain_done act=%b exp=00", done_valid); else passed++;
      total++; if (req_grant !== 2'b01) $display("FAIL sq_regrant act=%b exp=01", req_grant); else passed++;
      step();
      req_valid = 0;
      #1;
      total++; if (mem_command !== BUS_LOAD) $display("FAIL sq_issue_cmd act=%0d exp=%0d", mem_command, BUS_LOAD); else passed++;
      squash = 1; mem_response = 4'd6;
      #1;
      total++; if (mem_command !== BUS_NONE) $display("FAIL sq_force_none act=%0d exp=%0d", mem_command, BUS_NONE); else passed++;
      step();
      squash = 0; mem_response = 0; req_valid = 2'b01;
      #1;
      total++; if (req_grant !== 2'b00) $display("FAIL sq_issue_drain act=%b exp=00", req_grant); else passed++;
      mem_tag = 4'd6;
      step();
      mem_tag = 0;
      #1;
      total++; if (done_valid !== 2'b00) $display("FAIL sq_issue_done act=%b exp=00", done_valid); else passed++;
      total++; if (req_grant !== 2'b01) $display("FAIL sq_issue_regrant act=%b exp=01", req_grant); else passed++;
      clear_inputs();
      step();
      squash = 1;
      step();
      squash = 0;
      #1;
      total++; if (mem_command !== BUS_NONE) $display("FAIL sq_issue_idle act=%0d exp=%0d", mem_command, BUS_NONE); else passed++;
   endtask
   task automatic test_reset_mid();
      do_reset();
      req_valid = 2'b01; req_rd_mem = 2'b01; req_addr[0] = 32'h80; req_wdata[0] = 32'h55; req_size[0] = 3'd2; req_dest[0] = 5'd4;
      step();
      req_valid = 0;
      #1;
      total++; if (mem_command !== BUS_LOAD) $display("FAIL rm_cmd act=%0d exp=%0d", mem_command, BUS_LOAD); else passed++;
      reset = 1;
      step();
      reset = 0;
      #1;
      total++; if (mem_command !== BUS_NONE) $display("FAIL rm_none act=%0d exp=%0d", mem_command, BUS_NONE); else passed++;
      total++; if (mem_addr !== 32'h0) $display("FAIL rm_addr act=%h exp=0", mem_addr); else passed++;
      total++; if (mem_wdata !== 32'h0) $display("FAIL rm_wdata act=%h exp=0", mem_wdata); else passed++;
      total++; if (done_valid !== 2'b00 || done_data !== 32'h0 || done_dest !== 5'd0)
         $display("FAIL rm_done act=%b/%h/%0d exp=00/0/0", done_valid, done_data, done_dest); else passed++;
      mem_response = 4'd3;
      step();
      mem_response = 0; mem_tag = 4'd3; mem_rdata = 32'h1;
      step();
      mem_tag = 0;
      total++; if (done_valid !== 2'b00) $display("FAIL rm_late act=%b exp=00", done_valid); else passed++;
      total++; if (mem_command !== BUS_NONE) $display("FAIL rm_late_cmd act=%0d exp=%0d", mem_command, BUS_NONE); else passed++;
   endtask
   task automatic test_random();
      logic [2:0]  lsz [5];
      logic [1:0]  v, eoh;
      logic [31:0] e_addr, e_wdata, rd;
      logic [2:0]  e_size;
      logic [4:0]  e_dest;
      logic [3:0]  tag;
      BUS_COMMAND  e_cmd;
      int          rr, win, k;
      bit          st;
      lsz = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      do_reset();
      rr = 0;
      for (int n = 0; n < 40; n++) begin
         v = 2'($urandom_range(1, 3));
         for (int r = 0; r < 2; r++) begin
            st = 1'($urandom_range(0, 1));
            req_rd_mem[r] = !st; req_wr_mem[r] = st;
            req_addr[r] = $urandom; req_wdata[r] = $urandom; req_dest[r] = 5'($urandom_range(0, 31));
            req_size[r] = st ? 3'($urandom_range(0, 2)) : lsz[$urandom_range(0, 4)];
         end
         req_valid = v;
         win = (v == 2'b11) ? rr : (v == 2'b10 ? 1 : 0);
         rr = 1 - win;
         eoh = 2'b01 << win;
         st = req_wr_mem[win]; e_addr = req_addr[win]; e_wdata = req_wdata[win];
         e_size = req_size[win]; e_dest = req_dest[win];
         e_cmd = st ? BUS_STORE : BUS_LOAD;
         #1;
         total++; if (req_grant !== eoh) $display("FAIL rnd_grant%0d act=%b exp=%b", n, req_grant, eoh); else passed++;
         step();
         req_valid = 0;
         k = $urandom_range(0, 2);
         repeat (k) begin
            #1;
            total++; if (mem_command !== e_cmd) $display("FAIL rnd_hold%0d act=%0d exp=%0d", n, mem_command, e_cmd); else passed++;
            step();
         end
         tag = 4'($urandom_range(1, 15));
         mem_response = tag;
         #1;
         total++; if (mem_command !== e_cmd || mem_addr !== e_addr || mem_size !== MEM_SIZE'(e_size[1:0]) || (st && mem_wdata !== e_wdata))
            $display("FAIL rnd_issue%0d act=%0d/%h/%h exp=%0d/%h/%h", n, mem_command, mem_addr, mem_wdata, e_cmd, e_addr, e_wdata); else passed++;
         step();
         mem_response = 0;
         if (st) begin
            total++; if (done_valid !== eoh || done_data !== 32'h0)
               $display("FAIL rnd_st_done%0d act=%b/%h exp=%b/0", n, done_valid, done_data, eoh); else passed++;
         end else begin
            k = $urandom_range(0, 3);
            repeat (k) begin
               mem_tag = 4'((int'(tag) % 15) + 1); mem_rdata = $urandom;
               #1;
               total++; if (done_valid !== 2'b00 || mem_command !== BUS_NONE)
                  $display("FAIL rnd_wait%0d act=%b/%0d exp=00/%0d", n, done_valid, mem_command, BUS_NONE); else passed++;
               step();
            end
            rd = $urandom;
            mem_tag = tag; mem_rdata = rd;
            step();
            mem_tag = 0;
            total++; if (done_valid !== eoh || done_data !== ref_ld(rd, int'(e_addr[1:0]), e_size) || done_dest !== e_dest)
               $display("FAIL rnd_ld_done%0d act=%b/%h/%0d exp=%b/%h/%0d", n, done_valid, done_data, done_dest,
                        eoh, ref_ld(rd, int'(e_addr[1:0]), e_size), e_dest); else passed++;
         end
      end
      clear_inputs();
   endtask
   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_single_load();
      test_contention();
      test_load_extract();
      test_store_backpressure();
      test_squash();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
